birds_hit_detector: RTL and testbench

BIRDS_HIT_DETECTOR -- requirements
Module: birds_hit_detector

---
 rtl/birds_hit_detector.sv | 188 ++++++++++++++++++
 tb/tb_birds_hit_detector.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/birds_hit_detector.sv
// Per-frame shot/bird overlap detector with armed start-up window and saturating hit score.
// Optional bird-to-bird collision pulse is built only when BIRDS_COLLIDE_EN is defined.
module birds_hit_detector #(
    parameter int SCORE_WIDTH = 8,
    parameter int ARM_FRAMES  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   bird1DrawingRequest,
    input  logic                   bird2DrawingRequest,
    input  logic                   shotDrawingRequest,
    output logic                   bird1Hit,
    output logic                   bird2Hit,
    output logic                   birdsCollide,
    output logic [SCORE_WIDTH-1:0] hitCount,
    output logic                   armed
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int                     FCW        = $clog2(ARM_FRAMES + 2);
    localparam logic [FCW-1:0]         ARM_TARGET = FCW'(ARM_FRAMES);
    localparam logic [SCORE_WIDTH:0]   SCORE_MAX  = {1'b0, {SCORE_WIDTH{1'b1}}};

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   s1_r;
    logic                   s2_r;
    logic                   s1_next_s;
    logic                   s2_next_s;
    logic                   hit1_next_s;
    logic                   hit2_next_s;
    logic [FCW-1:0]         frame_cnt_r;
    logic [FCW-1:0]         frame_cnt_next_s;
    logic                   armed_next_s;
    logic [SCORE_WIDTH:0]   score_sum_s;
    logic [SCORE_WIDTH-1:0] score_next_s;
    logic                   s1_term_s;
    logic                   s2_term_s;
    logic                   close_frame_s;

    assign s1_term_s     = shotDrawingRequest & bird1DrawingRequest;
    assign s2_term_s     = shotDrawingRequest & bird2DrawingRequest;
    assign close_frame_s = (state_r == SCAN) && startOfFrame;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; startOfFrame during REPORT is deliberately ignored
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (startOfFrame) state_next_s = SCAN;
                else              state_next_s = IDLE;
            end
            SCAN: begin
                if (startOfFrame) state_next_s = REPORT;
                else              state_next_s = SCAN;
            end
            REPORT:  state_next_s = SCAN;
            default: state_next_s = IDLE;
        endcase
    end

    // Output/datapath next values: sticky flags, report pulses, arming and score
    always_comb begin
        s1_next_s        = 1'b0;
        s2_next_s        = 1'b0;
        hit1_next_s      = 1'b0;
        hit2_next_s      = 1'b0;
        frame_cnt_next_s = frame_cnt_r;
        case (state_r)
            IDLE: begin
                s1_next_s = 1'b0;
                s2_next_s = 1'b0;
            end
            SCAN: begin
                if (startOfFrame) begin
                    // the coincident pixel opens the new frame, so it is not reported now
                    s1_next_s   = s1_term_s;
                    s2_next_s   = s2_term_s;
                    hit1_next_s = s1_r & armed;
                    hit2_next_s = s2_r & armed;
                end else begin
                    s1_next_s = s1_r | s1_term_s;
                    s2_next_s = s2_r | s2_term_s;
                end
            end
            REPORT: begin
                s1_next_s = s1_r | s1_term_s;
                s2_next_s = s2_r | s2_term_s;
            end
            default: begin
                s1_next_s = 1'b0;
                s2_next_s = 1'b0;
            end
        endcase

        if (close_frame_s && (frame_cnt_r != ARM_TARGET)) begin
            frame_cnt_next_s = frame_cnt_r + {{(FCW-1){1'b0}}, 1'b1};
        end else begin
            frame_cnt_next_s = frame_cnt_r;
        end
        armed_next_s = (frame_cnt_r >= ARM_TARGET);

        score_sum_s = {1'b0, hitCount}
                    + {{SCORE_WIDTH{1'b0}}, bird1Hit}
                    + {{SCORE_WIDTH{1'b0}}, bird2Hit};
        if ((state_r == REPORT) && armed) begin
            if (score_sum_s > SCORE_MAX) score_next_s = SCORE_MAX[SCORE_WIDTH-1:0];
            else                         score_next_s = score_sum_s[SCORE_WIDTH-1:0];
        end else begin
            score_next_s = hitCount;
        end
    end

    // Registered flags, pulses, frame counter, armed flag and score
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_r        <= 1'b0;
            s2_r        <= 1'b0;
            bird1Hit    <= 1'b0;
            bird2Hit    <= 1'b0;
            frame_cnt_r <= {FCW{1'b0}};
            armed       <= 1'b0;
            hitCount    <= {SCORE_WIDTH{1'b0}};
        end else begin
            s1_r        <= s1_next_s;
            s2_r        <= s2_next_s;
            bird1Hit    <= hit1_next_s;
            bird2Hit    <= hit2_next_s;
            frame_cnt_r <= frame_cnt_next_s;
            armed       <= armed_next_s;
            hitCount    <= score_next_s;
        end
    end

`ifdef BIRDS_COLLIDE_EN
    logic sc_r;
    logic sc_next_s;
    logic collide_next_s;

    // Bird-to-bird sticky flag and pulse, sequenced like the shot flags
    always_comb begin
        sc_next_s      = 1'b0;
        collide_next_s = 1'b0;
        case (state_r)
            IDLE: sc_next_s = 1'b0;
            SCAN: begin
                if (startOfFrame) begin
                    sc_next_s      = bird1DrawingRequest & bird2DrawingRequest;
                    collide_next_s = sc_r & armed;
                end else begin
                    sc_next_s = sc_r | (bird1DrawingRequest & bird2DrawingRequest);
                end
            end
            REPORT:  sc_next_s = sc_r | (bird1DrawingRequest & bird2DrawingRequest);
            default: sc_next_s = 1'b0;
        endcase
    end

    // Collision flag and pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sc_r         <= 1'b0;
            birdsCollide <= 1'b0;
        end else begin
            sc_r         <= sc_next_s;
            birdsCollide <= collide_next_s;
        end
    end
`else
    assign birdsCollide = 1'b0;
`endif

endmodule

// File: tb/tb_birds_hit_detector.sv
// Directed table-driven bench for birds_hit_detector (default and SCORE_WIDTH=2 instances).
module tb_birds_hit_detector;

`ifdef BIRDS_COLLIDE_EN
    localparam logic COL = 1'b1;
`else
    localparam logic COL = 1'b0;
`endif

    typedef struct {
        logic sof;
        logic b1;
        logic b2;
        logic sh;
        logic e1;
        logic e2;
        logic ec;
        logic earm;
        int   ecnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sof = 1'b0;
    logic       b1 = 1'b0;
    logic       b2 = 1'b0;
    logic       sh = 1'b0;
    logic       hit1, hit2, col, armed;
    logic [7:0] cnt;
    logic       s_hit1, s_hit2, s_col, s_armed;
    logic [1:0] s_cnt;

    int errors = 0;
    int checks = 0;

    vec_t tbl[25];

    birds_hit_detector #(.SCORE_WIDTH(8), .ARM_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .startOfFrame(sof),
        .bird1DrawingRequest(b1), .bird2DrawingRequest(b2), .shotDrawingRequest(sh),
        .bird1Hit(hit1), .bird2Hit(hit2), .birdsCollide(col),
        .hitCount(cnt), .armed(armed)
    );

    birds_hit_detector #(.SCORE_WIDTH(2), .ARM_FRAMES(2)) dut_sat (
        .clk(clk), .reset(reset), .startOfFrame(sof),
        .bird1DrawingRequest(b1), .bird2DrawingRequest(b2), .shotDrawingRequest(sh),
        .bird1Hit(s_hit1), .bird2Hit(s_hit2), .birdsCollide(s_col),
        .hitCount(s_cnt), .armed(s_armed)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic f, logic a, logic b, logic s,
                                logic x1, logic x2, logic xc, logic xa, int n);
        vec_t v;
        v.sof = f; v.b1 = a; v.b2 = b; v.sh = s;
        v.e1 = x1; v.e2 = x2; v.ec = xc; v.earm = xa; v.ecnt = n;
        return v;
    endfunction

    task automatic apply(input logic f, input logic a, input logic b, input logic s);
        @(negedge clk);
        sof = f; b1 = a; b2 = b; sh = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic x1, input logic x2,
                         input logic xc, input logic xa, input int n);
        logic [13:0] got;
        logic [13:0] exp;
        int          nsat;
        nsat = (n > 3) ? 3 : n;
        got  = {hit1, hit2, col, armed, cnt, s_cnt};
        exp  = {x1, x2, xc, xa, 8'(n), 2'(nsat)};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {hit1,hit2,col,armed,cnt,satcnt}=%h required %h", name, got, exp);
        end
    endtask

    initial begin
        //                 sof b1 b2 sh | e1 e2 ec arm cnt
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        tbl[13] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        tbl[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        tbl[17] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        tbl[18] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        tbl[19] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4);
        tbl[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        tbl[21] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        tbl[22] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, COL,  1'b1, 5);
        tbl[23] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        tbl[24] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            apply(tbl[i].sof, tbl[i].b1, tbl[i].b2, tbl[i].sh);
            check($sformatf("vec%0d", i), tbl[i].e1, tbl[i].e2, tbl[i].ec, tbl[i].earm, tbl[i].ecnt);
        end

        // Mid-frame reset with a pending overlap: outputs clear at once, frame is dropped
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b0;
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst_idle_sof", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst_report1", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        apply(1'b0, 1'b1, 1'b0, 1'b1);
        check("post_rst_scan", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst_report2", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_armed", 1'b0, 1'b0, 1'b0, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
